// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants and helpers for the fifo stream reader: word width,
// output-buffer depth and the depth of the fifo it reads from.
package fifo_stream_reader_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int BUF_DEPTH  = 2;
  localparam int FIFO_DEPTH = 8;

  typedef logic [1:0] occ_t;

  // True when buffered words plus the outstanding read, minus the word
  // leaving this cycle, still leave space for one more read.
  function automatic logic room_for_read(input occ_t occ, input logic inflight, input logic pop);
    logic [2:0] committed;
    committed = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    return (committed < 3'(BUF_DEPTH));
  endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry registered output buffer; head is entry 0, a pop shifts entry 1
// forward and a push lands in the first slot left free after that pop.
module skid_buf2
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output occ_t              occ
);

  logic [DATA_W-1:0] ent0, ent1, ent0_nxt, ent1_nxt;
  occ_t              occ_nxt, after_pop;

  // Next-state of the two entries and occupancy.
  always_comb begin
    ent0_nxt  = ent0;
    ent1_nxt  = ent1;
    after_pop = occ;
    occ_nxt   = occ;
    if (pop && (occ != 2'd0)) begin
      ent0_nxt  = ent1;
      after_pop = occ - 2'd1;
    end else begin
      after_pop = occ;
    end
    if (push) begin
      case (after_pop)
        2'd0: begin
          ent0_nxt = din;
          occ_nxt  = 2'd1;
        end
        2'd1: begin
          ent1_nxt = din;
          occ_nxt  = 2'd2;
        end
        // A full buffer is never pushed; the word is not stored.
        default: occ_nxt = after_pop;
      endcase
    end else begin
      occ_nxt = after_pop;
    end
  end

  // Entry and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent0 <= '0;
      ent1 <= '0;
      occ  <= 2'd0;
    end else begin
      ent0 <= ent0_nxt;
      ent1 <= ent1_nxt;
      occ  <= occ_nxt;
    end
  end

  assign head = ent0;

endmodule

// File: rtl/fifo_stream_reader.sv
// Reads words from a 1-cycle-latency fifo and streams them downstream through
// a 2-entry registered buffer with valid/ready handshake and a word counter.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  output logic              FIFO_RD,
  input  logic [DATA_W-1:0] FIFO_DOUT,
  input  logic              FIFO_VALID,
  input  logic              FIFO_EMPTY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [CNT_W-1:0]  WORD_CNT,
  output logic              DROP
);

  occ_t             occ;
  logic             inflight;
  logic             pop;
  logic             push;
  logic             underflow;
  logic             drop_q;
  logic [CNT_W-1:0] cnt;

  assign OUT_VALID = (occ != 2'd0);
  assign pop       = OUT_VALID & OUT_READY;
  assign push      = inflight & FIFO_VALID;
  assign underflow = inflight & ~FIFO_VALID;

  // Read strobe is combinational so a pop can be refilled in the same cycle;
  // reset gates it so it is low regardless of the clock.
  assign FIFO_RD = ~RST & EN & ~FIFO_EMPTY & room_for_read(occ, inflight, pop);

  skid_buf2 #(.DATA_W(DATA_W)) u_buf (
    .clk  (CLK),
    .rst  (RST),
    .push (push),
    .pop  (pop),
    .din  (FIFO_DOUT),
    .head (OUT_DATA),
    .occ  (occ)
  );

  // In-flight read tracker, underflow pulse and delivered-word counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      inflight <= 1'b0;
      drop_q   <= 1'b0;
      cnt      <= '0;
    end else begin
      inflight <= FIFO_RD;
      drop_q   <= underflow;
      if (pop) begin
        cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= cnt;
      end
    end
  end

  assign DROP     = drop_q;
  assign WORD_CNT = cnt;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomised scoreboard bench for fifo_stream_reader with a queue-based fifo
// model and a separate output monitor.
module tb_fifo_stream_reader;

  localparam int DW = 16;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          EN = 1'b0;
  logic          FIFO_VALID = 1'b0;
  logic          FIFO_EMPTY = 1'b1;
  logic          OUT_READY = 1'b0;
  logic [DW-1:0] FIFO_DOUT = '0;
  logic          FIFO_RD;
  logic [DW-1:0] OUT_DATA;
  logic          OUT_VALID;
  logic [CW-1:0] WORD_CNT;
  logic          DROP;

  always #5 CLK = ~CLK;

  fifo_stream_reader #(.DATA_W(DW), .CNT_W(CW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .EN         (EN),
    .FIFO_RD    (FIFO_RD),
    .FIFO_DOUT  (FIFO_DOUT),
    .FIFO_VALID (FIFO_VALID),
    .FIFO_EMPTY (FIFO_EMPTY),
    .OUT_DATA   (OUT_DATA),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .WORD_CNT   (WORD_CNT),
    .DROP       (DROP)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] fq[$];
  logic [15:0] exp_q[$];
  logic        rd_seen   = 1'b0;
  logic        force_bad = 1'b0;
  logic        bad_resp  = 1'b0;
  int          cyc       = 0;
  int          rd_count  = 0;
  int          first_rd  = -1;
  int          pops      = 0;
  int          first_pop = -1;
  int          last_pop  = -1;
  logic [15:0] last_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One clock cycle: fifo answers the read issued last cycle, then new inputs.
  task automatic step(input logic en_i, input logic rdy_i);
    logic [15:0] w;
    @(negedge CLK);
    cyc++;
    bad_resp = 1'b0;
    if (rd_seen) begin
      if (force_bad || fq.size() == 0) begin
        FIFO_VALID = 1'b0;
        FIFO_DOUT  = 16'($urandom);
        bad_resp   = 1'b1;
      end else begin
        w = fq.pop_front();
        FIFO_VALID = 1'b1;
        FIFO_DOUT  = w;
        exp_q.push_back(w);
      end
    end else begin
      FIFO_VALID = ($urandom_range(0, 3) == 0);
      FIFO_DOUT  = 16'($urandom);
    end
    force_bad  = 1'b0;
    FIFO_EMPTY = (fq.size() == 0);
    EN         = en_i;
    OUT_READY  = rdy_i;
    #1;
    rd_seen = FIFO_RD;
    if (FIFO_RD) begin
      rd_count++;
      if (first_rd < 0) first_rd = cyc;
    end
  endtask

  task automatic load(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) fq.push_back(base + 16'(i));
  endtask

  task automatic reset_counters();
    pops = 0; first_pop = -1; last_pop = -1; rd_count = 0; first_rd = -1;
  endtask

  task automatic drain(input int max_steps);
    int k;
    k = 0;
    while (k < max_steps && !(fq.size() == 0 && exp_q.size() == 0 && !rd_seen && !OUT_VALID)) begin
      step(1'b1, 1'b1);
      k++;
    end
    if (k >= max_steps) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d cycles elapsed, limit %0d", k, max_steps);
    end
    step(1'b0, 1'b1);
  endtask

  // Asserted mid-cycle so the outputs are checked before any clock edge.
  task automatic do_reset_async(input string tag);
    #2;
    RST = 1'b1;
    #1;
    chk({tag, "_fifo_rd"}, FIFO_RD, 1'b0);
    chk({tag, "_out_valid"}, OUT_VALID, 1'b0);
    chk({tag, "_out_data"}, OUT_DATA, 16'h0000);
    chk({tag, "_word_cnt"}, WORD_CNT, 4'h0);
    chk({tag, "_drop"}, DROP, 1'b0);
    fq.delete();
    exp_q.delete();
    rd_seen = 1'b0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    #2;
    RST = 1'b0;
  endtask

  // Monitor: scoreboard pop on every handshake plus hold/count/drop checks.
  logic        held = 1'b0;
  logic [15:0] held_data = '0;
  logic        last_bad = 1'b0;
  int          model_cnt = 0;

  always @(negedge CLK) begin
    #2;
    if (RST) begin
      held = 1'b0; last_bad = 1'b0; model_cnt = 0;
    end else begin
      chk("word_cnt", WORD_CNT, model_cnt % 16);
      chk("drop", DROP, last_bad);
      last_bad = bad_resp;
      if (held) begin
        chk("hold_valid", OUT_VALID, 1'b1);
        chk("hold_data", OUT_DATA, held_data);
      end
      if (OUT_VALID && OUT_READY) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_word: got %0h with no word expected", OUT_DATA);
        end else begin
          chk("data", OUT_DATA, exp_q.pop_front());
        end
        model_cnt++;
        pops++;
        if (first_pop < 0) first_pop = cyc;
        last_pop  = cyc;
        last_data = OUT_DATA;
      end
      held      = OUT_VALID && !OUT_READY;
      held_data = OUT_DATA;
    end
  end

  initial begin
    EN = 1'b1;
    FIFO_EMPTY = 1'b0;
    #1;
    chk("init_fifo_rd", FIFO_RD, 1'b0);
    chk("init_out_valid", OUT_VALID, 1'b0);
    chk("init_out_data", OUT_DATA, 16'h0000);
    chk("init_word_cnt", WORD_CNT, 4'h0);
    chk("init_drop", DROP, 1'b0);
    step(1'b1, 1'b0);
    #2;
    RST = 1'b0;

    // Streaming burst with ready held high.
    reset_counters();
    load(8, 16'h0001);
    drain(40);
    chk("t1_pops", pops, 8);
    chk("t1_latency", first_pop - first_rd, 2);
    chk("t1_back_to_back", last_pop - first_pop, 7);
    chk("t1_word_cnt", WORD_CNT, 4'd8);

    // Downstream stall: buffer fills to two and holds its head.
    reset_counters();
    load(8, 16'h0001);
    repeat (5) step(1'b1, 1'b0);
    chk("t2_rd_pulses", rd_count, 2);
    chk("t2_head_valid", OUT_VALID, 1'b1);
    chk("t2_head_data", OUT_DATA, 16'h0001);
    drain(40);
    chk("t2_pops", pops, 8);
    chk("t2_no_gap", last_pop - first_pop, 7);

    // Toggling ready with two words.
    reset_counters();
    fq.push_back(16'h000b);
    fq.push_back(16'h000c);
    for (int i = 0; i < 8; i++) step(1'b1, (i % 2) == 0);
    chk("t3_pops", pops, 2);
    chk("t3_fifo_empty", FIFO_EMPTY, 1'b1);
    chk("t3_rd_pulses", rd_count, 2);
    repeat (4) step(1'b1, 1'b1);
    chk("t3_no_more_rd", rd_count, 2);

    // Underflow on the cycle after a read.
    reset_counters();
    fq.push_back(16'h0055);
    fq.push_back(16'h0066);
    step(1'b1, 1'b0);
    force_bad = 1'b1;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("t4_drop_pulse", DROP, 1'b1);
    chk("t4_nothing_stored", OUT_VALID, 1'b0);
    step(1'b1, 1'b0);
    chk("t4_drop_one_cycle", DROP, 1'b0);
    drain(40);
    chk("t4_pops", pops, 2);

    // Randomised traffic with occasional underflows.
    reset_counters();
    repeat (400) begin
      if (fq.size() < 3 && $urandom_range(0, 3) == 0) fq.push_back(16'($urandom));
      if (rd_seen && $urandom_range(0, 7) == 0) force_bad = 1'b1;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end
    drain(60);

    // Reset mid-transfer discards buffered and in-flight words.
    load(20, 16'h2000);
    repeat (6) step(1'b1, 1'b1);
    do_reset_async("t6_rst");
    reset_counters();
    fq.push_back(16'h1111);
    drain(20);
    chk("t6_pops", pops, 1);
    chk("t6_first_word", last_data, 16'h1111);

    // Counter wrap on a 4-bit counter.
    do_reset_async("t7_rst");
    reset_counters();
    load(16, 16'h0300);
    drain(40);
    chk("t7_pops", pops, 16);
    chk("t7_wrap_zero", WORD_CNT, 4'd0);
    fq.push_back(16'h0abc);
    drain(20);
    chk("t7_after_wrap", WORD_CNT, 4'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
